// File: rtl/ble_tx_arbiter.sv
// ble_tx_arbiter: shares the BLE UART transmit path between N_REQ requesters.
// Packets are granted round-robin, one at a time. Payload bytes are forwarded
// to uart_tx, and every packet is closed with the 0x0A terminator.
// Optional feature macro: BLE_TX_TIMEOUT_EN enables the stalled-packet timeout.
module ble_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int MAX_LEN        = 255,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0][7:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      grant,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  framing_err,
  output logic                  timeout
);
  localparam int         IW        = $clog2(N_REQ);
  localparam logic [7:0] TERM_BYTE = 8'h0A;
  localparam logic [7:0] MAX_CNT   = 8'(MAX_LEN);

  // Reject parameter sets the far-end receiver cannot frame.
  if (N_REQ < 2 || MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("ble_tx_arbiter: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_GUARD, S_WAIT, S_TERM, S_TGUARD, S_TWAIT
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] g_idx, g_idx_n, ptr, ptr_n;
  logic [7:0]    cnt, cnt_n;
  logic          last_q, last_n;
  logic [7:0]    tx_data_n;
  logic          tx_start_n, ferr_n;
  logic          sel_valid, sel_last, accept;
  logic [7:0]    sel_data;
  logic          arb_hit;
  logic [IW-1:0] arb_idx, cand;
  int            arb_j;

`ifdef BLE_TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          tmo_n;
`endif

  assign sel_valid = req_valid[g_idx];
  assign sel_last  = req_last[g_idx];
  assign sel_data  = req_data[g_idx];
  assign accept    = (state == S_SEND) && sel_valid && !tx_busy;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign req_ready[i] = accept && (g_idx == IW'(i));
    assign grant[i]     = (state != S_IDLE) && (g_idx == IW'(i));
  end

  // Round-robin pick: first requesting lane at or above ptr, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    arb_j   = 0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_j = int'(ptr) + k;
      if (arb_j >= N_REQ) arb_j = arb_j - N_REQ;
      cand = IW'(arb_j);
      if (!arb_hit && req_valid[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // Packet FSM: next state plus the next values of all registered outputs.
  always_comb begin
    state_n    = state;
    g_idx_n    = g_idx;
    ptr_n      = ptr;
    cnt_n      = cnt;
    last_n     = last_q;
    tx_data_n  = tx_data;
    tx_start_n = 1'b0;
    ferr_n     = 1'b0;
`ifdef BLE_TX_TIMEOUT_EN
    tcnt_n     = tcnt;
    tmo_n      = 1'b0;
`endif
    unique case (state)
      S_IDLE: if (arb_hit) begin
        g_idx_n = arb_idx;
        last_n  = 1'b0;
        state_n = S_SEND;
      end
      S_SEND: begin
        if (accept) begin
          if (sel_data != TERM_BYTE) begin
            tx_data_n  = sel_data;
            tx_start_n = 1'b1;
            cnt_n      = cnt + 8'd1;
            last_n     = sel_last;
            state_n    = S_GUARD;
          end else begin
            // A payload 0x0A would fake a frame boundary at the receiver.
            ferr_n = 1'b1;
            if (sel_last) state_n = S_TERM;
          end
        end
`ifdef BLE_TX_TIMEOUT_EN
        if (!sel_valid) begin
          tcnt_n = tcnt + TW'(1);
          if (tcnt_n == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_n   = 1'b1;
            state_n = S_TERM;
          end
        end else if (accept) begin
          tcnt_n = '0;
        end
`endif
      end
      // uart_tx raises busy only a cycle after the start pulse.
      S_GUARD: state_n = S_WAIT;
      S_WAIT: if (!tx_busy) state_n = (last_q || cnt == MAX_CNT) ? S_TERM : S_SEND;
      S_TERM: if (!tx_busy) begin
        tx_data_n  = TERM_BYTE;
        tx_start_n = 1'b1;
        state_n    = S_TGUARD;
      end
      S_TGUARD: state_n = S_TWAIT;
      S_TWAIT: if (!tx_busy) begin
        ptr_n   = (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + IW'(1);
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
`ifdef BLE_TX_TIMEOUT_EN
    if (state_n != S_SEND) tcnt_n = '0;
`endif
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      g_idx       <= '0;
      ptr         <= '0;
      cnt         <= '0;
      last_q      <= 1'b0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_n;
      g_idx       <= g_idx_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      last_q      <= last_n;
      tx_data     <= tx_data_n;
      tx_start    <= tx_start_n;
      framing_err <= ferr_n;
    end
  end

`ifdef BLE_TX_TIMEOUT_EN
  // Stall counter and timeout pulse register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt    <= tcnt_n;
      timeout <= tmo_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ble_tx_arbiter.sv
// Bench for ble_tx_arbiter (default build): table of single-requester packets
// plus hand sequences for round-robin, MAX_LEN split and mid-packet reset.
module tb_ble_tx_arbiter;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0][7:0] req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     grant;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             framing_err;
  logic             timeout;

  ble_tx_arbiter #(.N_REQ(N), .MAX_LEN(255), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .framing_err(framing_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // uart_tx model: busy from the cycle after tx_start for busy_len cycles.
  int busy_len = 4;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Wire monitor: log each transmitted byte with its owner.
  logic [7:0]   log_d[$];
  logic [N-1:0] log_g[$];
  int           ferr_cnt = 0;
  int           rel_cnt  = 0;
  logic         prev_busy = 1'b0, prev_start = 1'b0;
  logic [N-1:0] prev_grant = '0;
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      log_d.push_back(tx_data);
      log_g.push_back(grant);
      chk("start_while_busy", 32'(prev_busy), 0);
      chk("start_back_to_back", 32'(prev_start), 0);
    end
    if (framing_err) ferr_cnt++;
    if (prev_grant != '0 && grant == '0) rel_cnt++;
    prev_busy  = tx_busy;
    prev_start = tx_start;
    prev_grant = grant;
  end

  logic abort = 1'b0;

  // Present one byte on lane r until accepted. Call at a negedge.
  task automatic send_byte(input int r, input logic [7:0] d, input logic l);
    bit acc = 0;
    int n = 0;
    req_valid[r] = 1'b1;
    req_data[r]  = d;
    req_last[r]  = l;
    while (!acc && n < 2000 && !abort) begin
      #1;
      if (req_ready[r]) begin
        @(posedge clk);
        acc = 1;
      end
      @(negedge clk);
      n++;
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
    if (!acc && !abort) chk($sformatf("accept_lane%0d", r), 0, 1);
  endtask

  // Wait until n bytes are logged and the arbiter is idle again.
  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (!(log_d.size() >= n && grant == '0 && !tx_busy) && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (k >= budget) chk("wait_done_budget", 32'(log_d.size()), 32'(n));
  endtask

  // Single-requester packets; bytes MSB-first, last flag on final byte.
  typedef struct {
    int           r;
    int           n;
    logic [31:0]  b;
    int           ne;
    logic [39:0]  e;
    int           fe;
    int           busy;
  } vec_t;

  function automatic vec_t mk(input int r, input int n, input logic [31:0] b,
                              input int ne, input logic [39:0] e, input int fe,
                              input int busy);
    vec_t v;
    v.r = r; v.n = n; v.b = b; v.ne = ne; v.e = e; v.fe = fe; v.busy = busy;
    return v;
  endfunction

  function automatic logic [7:0] t3_byte(input int k);
    return 8'((k % 200) + 16);
  endfunction

  vec_t tbl [6];
  vec_t v;
  int   base, fbase, rbase, idx;

  initial begin
    tbl[0] = mk(0, 2, 32'h10F0_0000, 3, 40'h10F00A_0000, 0, 10);
    tbl[1] = mk(1, 3, 32'h410A_4200, 3, 40'h41420A_0000, 1, 4);
    tbl[2] = mk(3, 1, 32'h0A00_0000, 1, 40'h0A0000_0000, 1, 4);
    tbl[3] = mk(2, 2, 32'h0A0A_0000, 1, 40'h0A0000_0000, 2, 4);
    tbl[4] = mk(0, 2, 32'h550A_0000, 2, 40'h550A00_0000, 1, 4);
    tbl[5] = mk(3, 3, 32'h7F80_FF00, 4, 40'h7F80FF_0A00, 0, 3);

    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_framing_err", 32'(framing_err), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four simultaneous requests, lane 0 queues a second packet.
    busy_len = 4;
    base = log_d.size();
    fork
      begin send_byte(0, 8'h30, 1'b1); send_byte(0, 8'h34, 1'b1); end
      send_byte(1, 8'h31, 1'b1);
      send_byte(2, 8'h32, 1'b1);
      send_byte(3, 8'h33, 1'b1);
    join
    wait_done(base + 10, 500);
    chk("rr_count", 32'(log_d.size() - base), 10);
    for (int p = 0; p < 5; p++) begin
      idx = (p == 4) ? 0 : p;
      if (log_d.size() >= base + 2 * p + 2) begin
        chk($sformatf("rr_pkt%0d_byte", p), 32'(log_d[base + 2 * p]), 32'h30 + 32'(p));
        chk($sformatf("rr_pkt%0d_term", p), 32'(log_d[base + 2 * p + 1]), 32'h0A);
        chk($sformatf("rr_pkt%0d_grant", p), 32'(log_g[base + 2 * p]), 32'(1) << idx);
        chk($sformatf("rr_pkt%0d_tgrant", p), 32'(log_g[base + 2 * p + 1]), 32'(1) << idx);
      end
    end

    // Table of single-requester packets.
    for (int t = 0; t < 6; t++) begin
      v = tbl[t];
      busy_len = v.busy;
      base = log_d.size();
      fbase = ferr_cnt;
      for (int i = 0; i < v.n; i++) send_byte(v.r, v.b[31 - 8 * i -: 8], i == v.n - 1);
      wait_done(base + v.ne, 500);
      chk($sformatf("v%0d_count", t), 32'(log_d.size() - base), 32'(v.ne));
      for (int i = 0; i < v.ne; i++) begin
        if (log_d.size() > base + i) begin
          chk($sformatf("v%0d_byte%0d", t, i), 32'(log_d[base + i]), 32'(v.e[39 - 8 * i -: 8]));
          chk($sformatf("v%0d_grant%0d", t, i), 32'(log_g[base + i]), 32'(1) << v.r);
        end
      end
      chk($sformatf("v%0d_framing", t), 32'(ferr_cnt - fbase), 32'(v.fe));
      chk($sformatf("v%0d_released", t), 32'(grant), 0);
    end

    // Lane 2 streams 300 bytes: split at 255 with a terminator.
    busy_len = 2;
    base = log_d.size();
    rbase = rel_cnt;
    for (int k = 0; k < 300; k++) send_byte(2, t3_byte(k), k == 299);
    wait_done(base + 302, 3000);
    chk("long_count", 32'(log_d.size() - base), 302);
    if (log_d.size() >= base + 302) begin
      for (int k = 0; k < 302; k++) begin
        if (k == 255 || k == 301)
          chk($sformatf("long_term%0d", k), 32'(log_d[base + k]), 32'h0A);
        else
          chk($sformatf("long_byte%0d", k), 32'(log_d[base + k]),
              32'(t3_byte(k < 255 ? k : k - 1)));
        chk($sformatf("long_grant%0d", k), 32'(log_g[base + k]), 32'b0100);
      end
    end
    chk("long_releases", 32'(rel_cnt - rbase), 2);

    // Reset in WAIT of byte 3: packet aborted, no terminator.
    busy_len = 10;
    base = log_d.size();
    fork
      begin
        for (int k = 0; k < 5; k++) if (!abort) send_byte(1, 8'(8'h51 + k), k == 4);
      end
      begin
        int n = 0;
        while (log_d.size() < base + 3 && n < 400) begin
          @(negedge clk);
          #2;
          n++;
        end
        chk("rst_mid_third_start", 32'(log_d.size() >= base + 3), 1);
        @(negedge clk);
        rst_n = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_grant", 32'(grant), 0);
        chk("rst_mid_tx_start", 32'(tx_start), 0);
        chk("rst_mid_tx_data", 32'(tx_data), 0);
        chk("rst_mid_framing_err", 32'(framing_err), 0);
        chk("rst_mid_timeout", 32'(timeout), 0);
        chk("rst_mid_req_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
      end
    join
    abort = 1'b0;
    send_byte(1, 8'h66, 1'b1);
    wait_done(base + 5, 500);
    chk("rst_mid_count", 32'(log_d.size() - base), 5);
    if (log_d.size() >= base + 5) begin
      chk("rst_mid_pre_bytes", 32'({log_d[base], log_d[base + 1], log_d[base + 2]}), 32'h515253);
      chk("rst_mid_new_byte", 32'(log_d[base + 3]), 32'h66);
      chk("rst_mid_new_term", 32'(log_d[base + 4]), 32'h0A);
    end
    chk("timeout_idle", 32'(timeout), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
